hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LAT, default 4, multi-cycle (mult/div) latency in cycles, legal range 2..15.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports RsD, RtD, input, REG_AW, decode-stage source registers.
REQ-007 SHALL have ports BranchD and MdReqD, input, 1: branch in decode; mult/div op in decode.
REQ-008 SHALL have ports RsE, RtE, WriteRegE, input, REG_AW, execute-stage sources and destination.
REQ-009 SHALL have ports RegWriteE, MemtoRegE, MdStartE, input, 1: execute write-enable, load in execute, mult/div issue from execute.
REQ-010 SHALL have ports WriteRegM (REG_AW), RegWriteM, MemtoRegM (1), inputs, memory-stage destination and controls.
REQ-011 SHALL have ports WriteRegW (REG_AW), RegWriteW (1), inputs, writeback-stage destination and enable.
REQ-012 SHALL have ports ForwardAE, ForwardBE, output, 2: execute operand mux selects.
REQ-013 SHALL have ports ForwardAD, ForwardBD, output, 1: decode branch-compare forward from memory stage.
REQ-014 SHALL have ports StallF, StallD, FlushE, output, 1: pipeline control.
REQ-015 SHALL have ports MdBusy, MdDoneW (1) and MdWriteRegW (REG_AW), outputs: unit occupied, result writeback this cycle, result destination.
REQ-016 SHALL have port StallCount, output, CNT_W: saturating count of stalled cycles.

Function
REQ-017 A "match(s,d,en)" SHALL mean s!=0 and s==d and en.
REQ-018 ForwardAE SHALL be 2'b10 if match(RsE,WriteRegM,RegWriteM), else 2'b01 if match(RsE,WriteRegW,RegWriteW), else 2'b00; ForwardBE identical using RtE; memory stage wins when both match.
REQ-019 ForwardAD SHALL equal match(RsD,WriteRegM,RegWriteM); ForwardBD the same using RtD.
REQ-020 lwstall SHALL equal MemtoRegE and (match(RsD,WriteRegE,RegWriteE) or match(RtD,WriteRegE,RegWriteE)).
REQ-021 brstall SHALL equal BranchD and (match(Rs/RtD,WriteRegE,RegWriteE) or match(Rs/RtD,WriteRegM,MemtoRegM)).
REQ-022 mdstall SHALL equal MdBusy and not MdDoneW and (match(RsD,MdWriteRegW,1) or match(RtD,MdWriteRegW,1) or MdReqD).
REQ-023 StallF, StallD and FlushE SHALL all equal lwstall or brstall or mdstall, combinationally, in the same cycle.
REQ-024 Mult/div tracker SHALL have states IDLE and BUSY plus a down-counter of width 4.
REQ-025 IDLE and MdStartE: next state BUSY, counter loaded MD_LAT-1, MdWriteRegW latched from WriteRegE.
REQ-026 BUSY: counter decrements each cycle; MdDoneW=1 exactly when counter==0; result is written MD_LAT cycles after the issue edge.
REQ-027 BUSY with counter==0 and no MdStartE: next state IDLE; with MdStartE: reload (back-to-back issue, no bubble).
REQ-028 MdStartE in BUSY with counter!=0 SHALL be ignored (cannot occur legally because of REQ-022).
REQ-029 MdBusy SHALL be 1 in BUSY, 0 in IDLE; MdWriteRegW holds its value in IDLE.
REQ-030 StallCount SHALL increment by 1 on each cycle StallD=1 and saturate at all-ones.

Reset
REQ-031 On reset=1 at a clock edge: state IDLE, counter 0, MdWriteRegW 0, StallCount 0; reset overrides MdStartE.
REQ-032 After reset, MdBusy=0 and MdDoneW=0; the combinational outputs depend only on inputs.

Structure
REQ-033 Package hazard_pkg SHALL hold FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the IDLE/BUSY state encoding.
REQ-034 Comparator REQ-017 SHALL be sub-module reg_match (parameter REG_AW), instantiated per comparison.

Verification
REQ-035 RsE=RtE=3, WriteRegM=WriteRegW=3, both RegWrite=1 -> ForwardAE=ForwardBE=2'b10; then RegWriteM=0 -> 2'b01; with RsE=0 -> 2'b00.
REQ-036 MemtoRegE=1, RegWriteE=1, WriteRegE=8, RsD=8 -> StallF=StallD=FlushE=1 for that cycle; StallCount increments 0->1.
REQ-037 BranchD=1, RsD=9, WriteRegM=9, MemtoRegM=1 -> stall; MemtoRegM=0, RegWriteM=1 -> no stall, ForwardAD=1.
REQ-038 MdStartE with WriteRegE=12, MD_LAT=4 -> MdBusy for 4 cycles, MdDoneW on 4th with MdWriteRegW=12; RsD=12 stalls cycles 1-3 only.
REQ-039 MdStartE on the MdDoneW cycle -> tracker stays BUSY, new destination latched, no bubble; reset asserted mid-BUSY -> IDLE next edge.
REQ-040 Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> StallCount holds 4'hF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding mux selects and
// the mult/div tracker state.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/reg_match.sv
// Register dependency comparator: hit when the source is a real register
// (not r0), equals the destination, and the destination is being written.
module reg_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] s_i,
    input  logic [REG_AW-1:0] d_i,
    input  logic              en_i,
    output logic              hit_o
);

    assign hit_o = en_i && (s_i != '0) && (s_i == d_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load/branch/mult-div stalls,
// a fixed-latency mult/div result tracker and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              BranchD,
    input  logic              MdReqD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MdStartE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              MdBusy,
    output logic              MdDoneW,
    output logic [REG_AW-1:0] MdWriteRegW,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int          NCMP    = 12;
    localparam logic [3:0]  MD_LOAD = 4'(MD_LAT - 1);

    // Comparator slots; source/dest/enable vectors below are ordered 11..0.
    localparam int C_AE_M = 0, C_AE_W = 1, C_BE_M = 2, C_BE_W = 3;
    localparam int C_AD_M = 4, C_BD_M = 5, C_SD_E = 6, C_TD_E = 7;
    localparam int C_SD_L = 8, C_TD_L = 9, C_SD_MD = 10, C_TD_MD = 11;

    logic [NCMP-1:0][REG_AW-1:0] cmp_s, cmp_d;
    logic [NCMP-1:0]             cmp_en, hit;

    md_state_e             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [REG_AW-1:0]     mdreg_q, mdreg_d;
    logic [CNT_W-1:0]      scnt_q, scnt_d;
    logic                  lwstall, brstall, mdstall, stall;

    assign cmp_s  = {RtD, RsD, RtD, RsD, RtD, RsD, RtD, RsD, RtE, RtE, RsE, RsE};
    assign cmp_d  = {mdreg_q, mdreg_q, WriteRegM, WriteRegM, WriteRegE, WriteRegE,
                     WriteRegM, WriteRegM, WriteRegW, WriteRegM, WriteRegW, WriteRegM};
    assign cmp_en = {1'b1, 1'b1, MemtoRegM, MemtoRegM, RegWriteE, RegWriteE,
                     RegWriteM, RegWriteM, RegWriteW, RegWriteM, RegWriteW, RegWriteM};

    for (genvar i = 0; i < NCMP; i++) begin : g_cmp
        reg_match #(.REG_AW(REG_AW)) u_match (
            .s_i  (cmp_s[i]),
            .d_i  (cmp_d[i]),
            .en_i (cmp_en[i]),
            .hit_o(hit[i])
        );
    end

    // Memory stage holds the younger result, so it takes priority.
    assign ForwardAE = hit[C_AE_M] ? FWD_MEM : hit[C_AE_W] ? FWD_WB : FWD_NONE;
    assign ForwardBE = hit[C_BE_M] ? FWD_MEM : hit[C_BE_W] ? FWD_WB : FWD_NONE;
    assign ForwardAD = hit[C_AD_M];
    assign ForwardBD = hit[C_BD_M];

    assign MdBusy      = (state_q == MD_BUSY);
    assign MdDoneW     = MdBusy && (cnt_q == 4'd0);
    assign MdWriteRegW = mdreg_q;

    assign lwstall = MemtoRegE && (hit[C_SD_E] || hit[C_TD_E]);
    assign brstall = BranchD && (hit[C_SD_E] || hit[C_TD_E] || hit[C_SD_L] || hit[C_TD_L]);
    assign mdstall = MdBusy && !MdDoneW && (hit[C_SD_MD] || hit[C_TD_MD] || MdReqD);
    assign stall   = lwstall || brstall || mdstall;

    assign StallF     = stall;
    assign StallD     = stall;
    assign FlushE     = stall;
    assign StallCount = scnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdreg_d = mdreg_q;
        case (state_q)
            MD_IDLE: begin
                if (MdStartE) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_LOAD;
                    mdreg_d = WriteRegE;
                end
            end
            MD_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (MdStartE) begin
                    // Back-to-back issue on the writeback cycle: no idle bubble.
                    cnt_d   = MD_LOAD;
                    mdreg_d = WriteRegE;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        scnt_d = scnt_q;
        if (stall && (scnt_q != '1)) scnt_d = scnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
            mdreg_q <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdreg_q <= mdreg_d;
            scnt_q  <= scnt_d;
        end
    end

endmodule
